dmem_access_ctrl: RTL and testbench

- Multi-cycle data-memory access controller between the CPU MEM-stage control signals (MemRead, MemWrite, addr, w_data) and the single-port data SRAM (memory1c-style: enable/wr/addr/data_in, combinational data_out).
- Holds the pipeline stalled for a fixed access latency and issues exactly one SRAM access per request.
- Registers read data onto mems_data_out, which feeds the load/LLB/LHB result mux in the MEM stage.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_lat_cnt.sv | 23 ++
 rtl/dmem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int          DMEM_DEFAULT_LATENCY = 4;
  localparam logic [15:0] DMEM_ALIGN_MASK      = 16'hFFFE;

endpackage

// File: rtl/dmem_lat_cnt.sv
// Loadable 4-bit down-counter timing the access latency; saturates at zero.
module dmem_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= 4'd0;
    else if (load)
      count <= load_val;
    else if (dec && (count != 4'd0))
      count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory access controller: stalls the pipeline for LATENCY
// cycles and issues exactly one SRAM access per MEM-stage request.
//
//   state | meaning
//   IDLE  | waiting; a request stalls combinationally and is captured
//   BUSY  | counting down; the counter==0 cycle is the SRAM access cycle
//   DONE  | stall released, misaligned pulse; request inputs ignored
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_DEFAULT_LATENCY,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] mems_data_out,
  output logic          stall,
  output logic          misaligned,
  output logic          sram_enable,
  output logic          sram_wr,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_data_in,
  input  logic [DW-1:0] sram_data_out
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  dmem_state_e   state, state_nxt;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          cap_wr, cap_mis;
  logic          req, capture, rd_latch;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [3:0]    cnt_val;

  // Gated by rst so a request held during reset cannot raise stall.
  assign req = (MemRead | MemWrite) & rst;

  dmem_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    capture     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    sram_enable = 1'b0;
    sram_wr     = 1'b0;
    rd_latch    = 1'b0;
    misaligned  = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) begin
          capture   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_zero) begin
          sram_enable = 1'b1;
          sram_wr     = cap_wr;
          rd_latch    = ~cap_wr;
          state_nxt   = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        misaligned = cap_mis;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when both strobes are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr <= '0;
      cap_data <= '0;
      cap_wr   <= 1'b0;
      cap_mis  <= 1'b0;
    end else if (capture) begin
      cap_addr <= {addr[AW-1:1], 1'b0};
      cap_data <= w_data;
      cap_wr   <= MemWrite;
      cap_mis  <= addr[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mems_data_out <= '0;
    else if (rd_latch)
      mems_data_out <= sram_data_out;
  end

  assign sram_addr    = cap_addr;
  assign sram_data_in = cap_data;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a LATENCY=4 and a LATENCY=2 instance,
// each with its own SRAM, driven by directed and random MEM-stage requests.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  typedef struct {
    logic        wr;
    logic [15:0] saddr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        mis;
    int          t_req;
  } exp_t;

  localparam int LAT [2] = '{4, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [15:0] addr_i    [2];
  logic [15:0] wdata_i   [2];
  logic [15:0] mems_o    [2];
  logic        stall_o   [2];
  logic        mis_o     [2];
  logic        sram_en   [2];
  logic        sram_wr   [2];
  logic [15:0] sram_addr [2];
  logic [15:0] sram_din  [2];
  logic [15:0] sram_dout [2];

  logic [15:0] env_mem [2][256];
  logic [15:0] ref_mem [2][256];
  logic [15:0] exp_mems [2];
  logic [15:0] mon_mems [2];
  exp_t        exp_q [2][$];
  exp_t        cur [2];
  logic        pend [2];
  int          cyc [2];
  int          en_cnt [2];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .addr(addr_i[0]), .w_data(wdata_i[0]), .mems_data_out(mems_o[0]),
    .stall(stall_o[0]), .misaligned(mis_o[0]), .sram_enable(sram_en[0]),
    .sram_wr(sram_wr[0]), .sram_addr(sram_addr[0]), .sram_data_in(sram_din[0]),
    .sram_data_out(sram_dout[0])
  );

  dmem_access_ctrl #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .addr(addr_i[1]), .w_data(wdata_i[1]), .mems_data_out(mems_o[1]),
    .stall(stall_o[1]), .misaligned(mis_o[1]), .sram_enable(sram_en[1]),
    .sram_wr(sram_wr[1]), .sram_addr(sram_addr[1]), .sram_data_in(sram_din[1]),
    .sram_data_out(sram_dout[1])
  );

  // Single-port SRAMs with combinational read, word-indexed.
  assign sram_dout[0] = env_mem[0][sram_addr[0][8:1]];
  assign sram_dout[1] = env_mem[1][sram_addr[1][8:1]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (sram_en[k] && sram_wr[k]) env_mem[k][sram_addr[k][8:1]] = sram_din[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per SRAM access and checks the DONE cycle after it.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        chk("rst_stall", {31'd0, stall_o[k]}, 32'd0);
        chk("rst_sram_en", {31'd0, sram_en[k]}, 32'd0);
        chk("rst_mems", {16'd0, mems_o[k]}, 32'd0);
        chk("rst_mis", {31'd0, mis_o[k]}, 32'd0);
        pend[k] = 1'b0;
        mon_mems[k] = 16'h0000;
      end else begin
        chk("stall", {31'd0, stall_o[k]}, {31'd0, exp_q[k].size() != 0});
        if (sram_en[k]) begin
          en_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            chk("unexpected_access", 32'd1, 32'd0);
          end else begin
            cur[k] = exp_q[k].pop_front();
            chk("sram_wr", {31'd0, sram_wr[k]}, {31'd0, cur[k].wr});
            chk("sram_addr", {16'd0, sram_addr[k]}, {16'd0, cur[k].saddr});
            if (cur[k].wr) chk("sram_data_in", {16'd0, sram_din[k]}, {16'd0, cur[k].wdata});
            chk("access_cycle", cyc[k] - cur[k].t_req, LAT[k] - 1);
            pend[k] = 1'b1;
          end
        end else begin
          chk("sram_wr_idle", {31'd0, sram_wr[k]}, 32'd0);
          if (pend[k]) begin
            chk("misaligned", {31'd0, mis_o[k]}, {31'd0, cur[k].mis});
            mon_mems[k] = cur[k].rdata;
            pend[k] = 1'b0;
          end else begin
            chk("misaligned_idle", {31'd0, mis_o[k]}, 32'd0);
          end
        end
        chk("mems_data_out", {16'd0, mems_o[k]}, {16'd0, mon_mems[k]});
      end
      cyc[k]++;
    end
  end

  task automatic preload(input int k, input logic [15:0] a, input logic [15:0] d);
    env_mem[k][a[8:1]] = d;
    ref_mem[k][a[8:1]] = d;
  endtask

  function automatic exp_t model(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.wr = wr;
    e.saddr = a & DMEM_ALIGN_MASK;
    e.wdata = d;
    e.mis = a[0];
    e.t_req = cyc[k];
    if (wr) begin
      ref_mem[k][e.saddr[8:1]] = d;
      e.rdata = exp_mems[k];
    end else begin
      e.rdata = ref_mem[k][e.saddr[8:1]];
      exp_mems[k] = e.rdata;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic issue(input int k, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    int w;
    mem_read[k] = rd;
    mem_write[k] = wr;
    addr_i[k] = a;
    wdata_i[k] = d;
    exp_q[k].push_back(model(k, wr, a, d));
    for (w = 0; w < 40; w++) begin
      @(negedge clk);
      if (!stall_o[k]) break;
      @(posedge clk); #1;
      addr_i[k] = 16'($urandom);
      wdata_i[k] = 16'($urandom);
    end
    if (w == 40) chk("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    mem_read[k] = 1'b0;
    mem_write[k] = 1'b0;
  endtask

  task automatic random_run(input int k, input int n);
    logic [15:0] a, d;
    int op;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom_range(0, 16'h01FF));
      d = 16'($urandom);
      op = $urandom_range(0, 2);
      issue(k, op != 1, op != 0, a, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        addr_i[k] = 16'($urandom);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        env_mem[k][i] = 16'h0000;
        ref_mem[k][i] = 16'h0000;
      end
      mem_read[k] = 1'b0; mem_write[k] = 1'b0;
      addr_i[k] = 16'h0000; wdata_i[k] = 16'h0000;
      exp_mems[k] = 16'h0000; mon_mems[k] = 16'h0000;
      pend[k] = 1'b0; cyc[k] = 0; en_cnt[k] = 0;
    end
    preload(0, 16'h0010, 16'hBEEF);
    preload(0, 16'h0040, 16'h5555);
    preload(1, 16'h0000, 16'hA0A0);
    preload(1, 16'h0002, 16'hB1B1);

    // Request held through reset must not stall until reset releases.
    mem_read[0] = 1'b1;
    addr_i[0] = 16'h0010;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("stall_on_release", {31'd0, stall_o[0]}, 32'd1);
    issue(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("read_beef", {16'd0, mems_o[0]}, 32'h0000BEEF);

    issue(0, 1'b0, 1'b1, 16'h0020, 16'h1234);
    chk("mems_hold_write", {16'd0, mems_o[0]}, 32'h0000BEEF);
    issue(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("read_after_write", {16'd0, mems_o[0]}, 32'h00001234);
    issue(0, 1'b1, 1'b1, 16'h0031, 16'h7777);
    chk("both_is_write", {16'd0, env_mem[0][8'h18]}, 32'h00007777);

    // Abandon a write two cycles into its stall.
    mem_write[0] = 1'b1;
    addr_i[0] = 16'h0040;
    wdata_i[0] = 16'hAAAA;
    begin
      exp_t e;
      e.wr = 1'b1; e.saddr = 16'h0040; e.wdata = 16'hAAAA;
      e.rdata = exp_mems[0]; e.mis = 1'b0; e.t_req = cyc[0];
      exp_q[0].push_back(e);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall_o[0]}, 32'd0);
    chk("mid_rst_sram_wr", {31'd0, sram_wr[0]}, 32'd0);
    exp_q[0].delete();
    exp_q[1].delete();
    exp_mems[0] = 16'h0000;
    exp_mems[1] = 16'h0000;
    mem_write[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abandoned_write", {16'd0, env_mem[0][8'h20]}, 32'h00005555);
    issue(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    chk("read_after_abort", {16'd0, mems_o[0]}, 32'h00005555);

    // LATENCY=2 back-to-back reads.
    en_cnt[1] = 0;
    issue(1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("b2b_first", {16'd0, mems_o[1]}, 32'h0000A0A0);
    issue(1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("b2b_second", {16'd0, mems_o[1]}, 32'h0000B1B1);
    chk("b2b_enables", en_cnt[1], 32'd2);

    random_run(0, 40);
    random_run(1, 40);
    repeat (3) @(posedge clk);
    chk("queue0_drained", exp_q[0].size(), 32'd0);
    chk("queue1_drained", exp_q[1].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
